// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image pipeline statistics stage.
//   PIX_W          : pixel width in bits
//   SUM_W_MAX      : width of the sum field carried in frame_stats_t; any
//                    instantiated frame sum width must not exceed it
//   state_t        : frame tracking FSM state (ST_IDLE, ST_ACTIVE)
//   frame_stats_t  : min/max/sum/mean record for one frame
// -----------------------------------------------------------------------------
package img_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned SUM_W_MAX = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0]     min_v;
        logic [PIX_W-1:0]     max_v;
        logic [SUM_W_MAX-1:0] sum_v;
        logic [PIX_W-1:0]     mean_v;
    } frame_stats_t;

endpackage

// File: rtl/frame_accum.sv
// -----------------------------------------------------------------------------
// frame_accum
// Running min/max/sum of the pixels of one frame plus the truncating mean.
// stats_o presents the values *including* the pixel accepted this cycle, so
// the parent can capture a complete record on the same edge as the eof pixel.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear_i    : drop the partial frame (ignored when a pixel is accepted,
//                since that pixel is then the seed of the new frame)
//   valid_i    : pixel_i is accepted this cycle
//   sof_i      : accepted pixel is the first of a frame (seeds accumulators)
//   pixel_i    : pixel value
//   stats_o    : next-state min/max/sum/mean
// -----------------------------------------------------------------------------
module frame_accum
    import img_pkg::*;
#(
    parameter int unsigned N_LOG2 = 6,
    parameter int unsigned SUM_W  = PIX_W + N_LOG2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic             sof_i,
    input  logic [PIX_W-1:0] pixel_i,
    output frame_stats_t     stats_o
);

    logic [PIX_W-1:0] min_q, min_d;
    logic [PIX_W-1:0] max_q, max_d;
    logic [SUM_W-1:0] sum_q, sum_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        sum_d = sum_q;
        if (valid_i) begin
            if (sof_i) begin
                min_d = pixel_i;
                max_d = pixel_i;
                sum_d = SUM_W'(pixel_i);
            end else begin
                min_d = (pixel_i < min_q) ? pixel_i : min_q;
                max_d = (pixel_i > max_q) ? pixel_i : max_q;
                sum_d = sum_q + SUM_W'(pixel_i);
            end
        end else if (clear_i) begin
            min_d = '0;
            max_d = '0;
            sum_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= '0;
            max_q <= '0;
            sum_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
            sum_q <= sum_d;
        end
    end

    always_comb begin
        stats_o.min_v  = min_d;
        stats_o.max_v  = max_d;
        stats_o.sum_v  = SUM_W_MAX'(sum_d);
        stats_o.mean_v = PIX_W'(sum_d >> N_LOG2);
    end

endmodule

// File: rtl/frame_stat_collector.sv
// -----------------------------------------------------------------------------
// frame_stat_collector
// Tags each accepted pixel with its raster position and sof/eol/eof markers and
// forwards it with one cycle of latency. With FRAME_STATS_EN defined, per-frame
// min/max/sum/mean are accumulated and offered through a valid/ready record at
// end of frame, with a sticky overrun flag. With FRAME_STATS_EN undefined the
// statistics outputs are tied to 0 and stats_ready is ignored.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   pixel_in, valid_in         : input pixel stream (no backpressure)
//   frame_restart              : synchronous resync to the start of a frame
//   pixel_out, valid_out       : registered pixel stream
//   x_out, y_out               : position of pixel_out
//   sof_out, eol_out, eof_out  : frame/line markers of pixel_out
//   stats_valid, stats_ready   : statistics record handshake
//   stat_min/max/sum/mean      : statistics record
//   stat_overrun               : sticky, record overwritten before acceptance
// -----------------------------------------------------------------------------
module frame_stat_collector
    import img_pkg::*;
#(
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8,
    localparam int unsigned XW    = $clog2(IMG_W),
    localparam int unsigned YW    = $clog2(IMG_H),
    localparam int unsigned SUM_W = PIX_W + XW + YW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             valid_in,
    input  logic             frame_restart,
    output logic [PIX_W-1:0] pixel_out,
    output logic             valid_out,
    output logic [XW-1:0]    x_out,
    output logic [YW-1:0]    y_out,
    output logic             sof_out,
    output logic             eol_out,
    output logic             eof_out,
    output logic             stats_valid,
    input  logic             stats_ready,
    output logic [PIX_W-1:0] stat_min,
    output logic [PIX_W-1:0] stat_max,
    output logic [PIX_W-1:0] stat_mean,
    output logic [SUM_W-1:0] stat_sum,
    output logic             stat_overrun
);

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d, x_cur;
    logic [YW-1:0]  y_q, y_d, y_cur;
    logic           last_col, last_row;
    logic           sof_d, eol_d, eof_d;

    // frame_restart acts as if the counters and FSM were already cleared, so a
    // pixel arriving in the same cycle is evaluated as the sof at (0,0).
    always_comb begin
        x_cur    = frame_restart ? '0 : x_q;
        y_cur    = frame_restart ? '0 : y_q;
        last_col = (x_cur == XW'(IMG_W - 1));
        last_row = (y_cur == YW'(IMG_H - 1));
        sof_d    = valid_in && (frame_restart || state_q == ST_IDLE);
        eol_d    = valid_in && last_col;
        eof_d    = valid_in && last_col && last_row;

        x_d      = x_cur;
        y_d      = y_cur;
        state_d  = frame_restart ? ST_IDLE : state_q;
        if (valid_in) begin
            x_d     = last_col ? '0 : x_cur + XW'(1);
            if (last_col) begin
                y_d = last_row ? '0 : y_cur + YW'(1);
            end
            state_d = eof_d ? ST_IDLE : ST_ACTIVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            pixel_out <= '0;
            valid_out <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            sof_out   <= 1'b0;
            eol_out   <= 1'b0;
            eof_out   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            valid_out <= valid_in;
            sof_out   <= sof_d;
            eol_out   <= eol_d;
            eof_out   <= eof_d;
            if (valid_in) begin
                pixel_out <= pixel_in;
                x_out     <= x_cur;
                y_out     <= y_cur;
            end
        end
    end

`ifdef FRAME_STATS_EN
    frame_stats_t acc_next;

    frame_accum #(
        .N_LOG2 (XW + YW),
        .SUM_W  (SUM_W)
    ) u_accum (
        .clk     (clk),
        .rst     (rst),
        .clear_i (frame_restart),
        .valid_i (valid_in),
        .sof_i   (sof_d),
        .pixel_i (pixel_in),
        .stats_o (acc_next)
    );

    if (SUM_W < SUM_W_MAX) begin : g_sum_hi
        logic unused_sum_hi;
        assign unused_sum_hi = ^acc_next.sum_v[SUM_W_MAX-1:SUM_W];
    end

    // A load takes priority over a ready-clear: the new record is held valid
    // even when the consumer accepts the old one in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stats_valid  <= 1'b0;
            stat_min     <= '0;
            stat_max     <= '0;
            stat_sum     <= '0;
            stat_mean    <= '0;
            stat_overrun <= 1'b0;
        end else if (eof_d) begin
            stats_valid <= 1'b1;
            stat_min    <= acc_next.min_v;
            stat_max    <= acc_next.max_v;
            stat_sum    <= acc_next.sum_v[SUM_W-1:0];
            stat_mean   <= acc_next.mean_v;
            if (stats_valid && !stats_ready) begin
                stat_overrun <= 1'b1;
            end
        end else if (stats_ready) begin
            stats_valid <= 1'b0;
        end
    end
`else
    logic unused_stats_ready;
    assign unused_stats_ready = stats_ready;

    assign stats_valid  = 1'b0;
    assign stat_min     = '0;
    assign stat_max     = '0;
    assign stat_sum     = '0;
    assign stat_mean    = '0;
    assign stat_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_frame_stat_collector.sv
module tb_frame_stat_collector;

    localparam int XW = 3;
    localparam int YW = 3;
`ifdef FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  pixel_in = '0;
    logic        valid_in = 1'b0;
    logic        frame_restart = 1'b0;
    logic        stats_ready = 1'b0;
    logic [7:0]  pixel_out;
    logic        valid_out;
    logic [2:0]  x_out;
    logic [2:0]  y_out;
    logic        sof_out, eol_out, eof_out;
    logic        stats_valid;
    logic [7:0]  stat_min, stat_max, stat_mean;
    logic [13:0] stat_sum;
    logic        stat_overrun;

    int checks = 0;
    int errors = 0;

    logic [17:0] obs_tag, exp_tag;
    logic [37:0] obs_st, exp_st;

    frame_stat_collector #(
        .IMG_W (8),
        .IMG_H (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pixel_in      (pixel_in),
        .valid_in      (valid_in),
        .frame_restart (frame_restart),
        .pixel_out     (pixel_out),
        .valid_out     (valid_out),
        .x_out         (x_out),
        .y_out         (y_out),
        .sof_out       (sof_out),
        .eol_out       (eol_out),
        .eof_out       (eof_out),
        .stats_valid   (stats_valid),
        .stats_ready   (stats_ready),
        .stat_min      (stat_min),
        .stat_max      (stat_max),
        .stat_mean     (stat_mean),
        .stat_sum      (stat_sum),
        .stat_overrun  (stat_overrun)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs at the falling edge; return 1 time unit after
    // the rising edge so outputs of the accepted pixel can be sampled.
    task automatic drive_cycle(input logic v, input logic [7:0] p,
                               input logic rs, input logic rdy);
        @(negedge clk);
        valid_in      = v;
        pixel_in      = p;
        frame_restart = rs;
        stats_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_in = 1'b0; frame_restart = 1'b0; stats_ready = 1'b0; pixel_in = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({pixel_out, valid_out, x_out, y_out, sof_out, eol_out, eof_out,
             stats_valid, stat_min, stat_max, stat_mean, stat_sum, stat_overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got pix=%h v=%b x=%0d y=%0d tags=%b%b%b sv=%b sum=%0d ovr=%b exp all 0",
                     pixel_out, valid_out, x_out, y_out, sof_out, eol_out, eof_out,
                     stats_valid, stat_sum, stat_overrun);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 64; i++) begin
            drive_cycle(1'b1, 8'(i), 1'b0, 1'b0);
            exp_tag = {1'b1, 8'(i), 3'(i % 8), 3'(i / 8), (i == 0), (i % 8 == 7), (i == 63)};
            obs_tag = {valid_out, pixel_out, x_out, y_out, sof_out, eol_out, eof_out};
            checks++;
            if (obs_tag !== exp_tag) begin
                errors++;
                $display("FAIL ramp_tags[%0d] got %h exp %h", i, obs_tag, exp_tag);
            end
            if (i == 62) begin
                checks++;
                if (stats_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ramp_sv_early got %b exp 0", stats_valid);
                end
            end
        end
        checks++;
        if (stats_valid !== STATS) begin
            errors++;
            $display("FAIL ramp_stats_valid got %b exp %b", stats_valid, STATS);
        end
        exp_st = STATS ? {8'd0, 8'd63, 14'd2016, 8'd31} : '0;
        obs_st = {stat_min, stat_max, stat_sum, stat_mean};
        checks++;
        if (obs_st !== exp_st) begin
            errors++;
            $display("FAIL ramp_stats got min=%0d max=%0d sum=%0d mean=%0d exp %h",
                     stat_min, stat_max, stat_sum, stat_mean, exp_st);
        end
        // idle cycle with ready: record consumed, no output pixel
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b1);
        checks++;
        if ({valid_out, sof_out, eol_out, eof_out, stats_valid} !== 5'b0) begin
            errors++;
            $display("FAIL ramp_idle got v=%b tags=%b%b%b sv=%b exp 0",
                     valid_out, sof_out, eol_out, eof_out, stats_valid);
        end
    endtask

    task automatic test_ramp_duty();
        int k;
        int cyc;
        logic v;
        k = 0;
        cyc = 0;
        while (k < 64 && cyc < 1000) begin
            v = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            drive_cycle(v, v ? 8'(k) : 8'hEE, 1'b0, 1'b0);
            cyc++;
            if (v) begin
                exp_tag = {1'b1, 8'(k), 3'(k % 8), 3'(k / 8), (k == 0), (k % 8 == 7), (k == 63)};
                obs_tag = {valid_out, pixel_out, x_out, y_out, sof_out, eol_out, eof_out};
                checks++;
                if (obs_tag !== exp_tag) begin
                    errors++;
                    $display("FAIL duty_tags[%0d] got %h exp %h", k, obs_tag, exp_tag);
                end
                k++;
            end else begin
                checks++;
                if ({valid_out, sof_out, eol_out, eof_out} !== 4'b0) begin
                    errors++;
                    $display("FAIL duty_gap[%0d] got v=%b tags=%b%b%b exp 0",
                             k, valid_out, sof_out, eol_out, eof_out);
                end
            end
        end
        checks++;
        if (k != 64) begin
            errors++;
            $display("FAIL duty_timeout got %0d pixels exp 64", k);
        end
        checks++;
        if (stats_valid !== STATS) begin
            errors++;
            $display("FAIL duty_stats_valid got %b exp %b", stats_valid, STATS);
        end
        exp_st = STATS ? {8'd0, 8'd63, 14'd2016, 8'd31} : '0;
        obs_st = {stat_min, stat_max, stat_sum, stat_mean};
        checks++;
        if (obs_st !== exp_st) begin
            errors++;
            $display("FAIL duty_stats got min=%0d max=%0d sum=%0d mean=%0d exp %h",
                     stat_min, stat_max, stat_sum, stat_mean, exp_st);
        end
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 64; i++) begin
            drive_cycle(1'b1, 8'd255, 1'b0, 1'b0);
        end
        exp_st = STATS ? {8'd255, 8'd255, 14'd16320, 8'd255} : '0;
        obs_st = {stat_min, stat_max, stat_sum, stat_mean};
        checks++;
        if ({obs_st, stats_valid, stat_overrun, eof_out} !== {exp_st, STATS, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovr_first got sum=%0d mean=%0d sv=%b ovr=%b eof=%b exp sum=%0d sv=%b ovr=0 eof=1",
                     stat_sum, stat_mean, stats_valid, stat_overrun, eof_out, exp_st[21:8], STATS);
        end
        // back-to-back second frame of zeros
        for (int i = 0; i < 64; i++) begin
            drive_cycle(1'b1, 8'd0, 1'b0, 1'b0);
            if (i == 0) begin
                checks++;
                if ({sof_out, x_out, y_out} !== 7'b1_000_000) begin
                    errors++;
                    $display("FAIL b2b_sof got sof=%b x=%0d y=%0d exp sof=1 at (0,0)",
                             sof_out, x_out, y_out);
                end
            end
        end
        obs_st = {stat_min, stat_max, stat_sum, stat_mean};
        checks++;
        if ({obs_st, stats_valid, stat_overrun} !== {38'd0, STATS, STATS}) begin
            errors++;
            $display("FAIL ovr_second got min=%0d max=%0d sum=%0d sv=%b ovr=%b exp all 0 sv=%b ovr=%b",
                     stat_min, stat_max, stat_sum, stats_valid, stat_overrun, STATS, STATS);
        end
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b1);
        checks++;
        if ({stats_valid, stat_overrun} !== {1'b0, STATS}) begin
            errors++;
            $display("FAIL ovr_sticky got sv=%b ovr=%b exp sv=0 ovr=%b", stats_valid, stat_overrun, STATS);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive_cycle(1'b1, 8'd7, 1'b0, 1'b0);
        end
        for (int i = 0; i < 64; i++) begin
            drive_cycle(1'b1, 8'd3, 1'b0, (i == 63));
        end
        exp_st = STATS ? {8'd3, 8'd3, 14'd192, 8'd3} : '0;
        obs_st = {stat_min, stat_max, stat_sum, stat_mean};
        checks++;
        if ({obs_st, stats_valid, stat_overrun} !== {exp_st, STATS, 1'b0}) begin
            errors++;
            $display("FAIL same_cycle got sum=%0d mean=%0d sv=%b ovr=%b exp sum=%0d sv=%b ovr=0",
                     stat_sum, stat_mean, stats_valid, stat_overrun, exp_st[21:8], STATS);
        end
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b1);
        checks++;
        if (stats_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_clear got sv=%b exp 0", stats_valid);
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b1, 8'(i + 40), 1'b0, 1'b0);
        end
        drive_cycle(1'b1, 8'd10, 1'b1, 1'b0);
        obs_tag = {valid_out, pixel_out, x_out, y_out, sof_out, eol_out, eof_out};
        exp_tag = {1'b1, 8'd10, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        checks++;
        if (obs_tag !== exp_tag) begin
            errors++;
            $display("FAIL restart_sof got %h exp %h", obs_tag, exp_tag);
        end
        for (int i = 1; i < 64; i++) begin
            drive_cycle(1'b1, 8'd10, 1'b0, 1'b0);
            if (i == 62) begin
                checks++;
                if ({eof_out, stats_valid} !== 2'b00) begin
                    errors++;
                    $display("FAIL restart_early got eof=%b sv=%b exp 0", eof_out, stats_valid);
                end
            end
        end
        checks++;
        if ({eof_out, x_out, y_out} !== 7'b1_111_111) begin
            errors++;
            $display("FAIL restart_eof got eof=%b x=%0d y=%0d exp eof=1 at (7,7)", eof_out, x_out, y_out);
        end
        exp_st = STATS ? {8'd10, 8'd10, 14'd640, 8'd10} : '0;
        obs_st = {stat_min, stat_max, stat_sum, stat_mean};
        checks++;
        if ({obs_st, stats_valid} !== {exp_st, STATS}) begin
            errors++;
            $display("FAIL restart_stats got min=%0d max=%0d sum=%0d mean=%0d sv=%b exp %h sv=%b",
                     stat_min, stat_max, stat_sum, stat_mean, stats_valid, exp_st, STATS);
        end
        drive_cycle(1'b0, 8'd0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 30; i++) begin
            drive_cycle(1'b1, 8'd100, 1'b0, 1'b0);
        end
        #3;
        rst = 1'b1;
        valid_in = 1'b0;
        #1;
        checks++;
        if ({pixel_out, valid_out, x_out, y_out, sof_out, eol_out, eof_out,
             stats_valid, stat_sum, stat_overrun} !== '0) begin
            errors++;
            $display("FAIL midreset_async got pix=%h v=%b x=%0d y=%0d sv=%b sum=%0d exp all 0",
                     pixel_out, valid_out, x_out, y_out, stats_valid, stat_sum);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            drive_cycle(1'b1, 8'd5, 1'b0, 1'b0);
            if (i == 0) begin
                checks++;
                if ({sof_out, x_out, y_out} !== 7'b1_000_000) begin
                    errors++;
                    $display("FAIL midreset_sof got sof=%b x=%0d y=%0d exp sof=1 at (0,0)",
                             sof_out, x_out, y_out);
                end
            end
        end
        exp_st = STATS ? {8'd5, 8'd5, 14'd320, 8'd5} : '0;
        obs_st = {stat_min, stat_max, stat_sum, stat_mean};
        checks++;
        if ({obs_st, stats_valid, eof_out} !== {exp_st, STATS, 1'b1}) begin
            errors++;
            $display("FAIL midreset_stats got min=%0d max=%0d sum=%0d sv=%b eof=%b exp %h sv=%b eof=1",
                     stat_min, stat_max, stat_sum, stats_valid, eof_out, exp_st, STATS);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_ramp_duty();
        test_overrun();
        test_same_cycle();
        test_restart();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_stat_collector.md
# frame_stat_collector

Downstream consumer of the brightness-reduction stage's 8-bit pixel stream (`pixel_out`/`valid_out`). Tags each pixel with its raster position, start-of-frame, end-of-line and end-of-frame markers, and forwards it with one cycle of latency. When enabled, it accumulates per-frame min, max, sum and mean, and presents them through a valid/ready handshake at end of frame. Sits between the pixel-processing stages and the file/monitor writer in the image pipeline.

## Interface
- `IMG_W`, 8: pixels per line; power of two, ≥ 2.
- `IMG_H`, 8: lines per frame; power of two, ≥ 2.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `pixel_in` in 8: pixel from the upstream stage.
- `valid_in` in 1: `pixel_in` is valid. No backpressure; every valid pixel is accepted.
- `frame_restart` in 1: synchronous resynchronisation pulse.
- `pixel_out` out 8: registered copy of the accepted pixel.
- `valid_out` out 1: `pixel_out` and its tags are valid.
- `x_out` out clog2(IMG_W): column of `pixel_out`.
- `y_out` out clog2(IMG_H): row of `pixel_out`.
- `sof_out`, `eol_out`, `eof_out` out 1 each: tags for the first pixel of the frame, the last pixel of a line, and the last pixel of the frame.
- `stats_valid` out 1: statistics record is available.
- `stats_ready` in 1: consumer accepts the statistics record.
- `stat_min`, `stat_max`, `stat_mean` out 8 each: frame minimum, maximum and mean.
- `stat_sum` out 8+clog2(IMG_W*IMG_H): frame sum; 14 bits at the defaults.
- `stat_overrun` out 1: sticky flag; a record was overwritten before it was accepted.

## Operation
- FSM has two states, IDLE and ACTIVE, and resets to IDLE.
  - IDLE → ACTIVE on an accepted pixel. That pixel is at (0,0) and gets `sof`.
  - ACTIVE → IDLE on acceptance of pixel (IMG_W-1, IMG_H-1). That pixel gets `eof`.
- Position counters x and y advance only on `valid_in`.
  - x wraps to 0 at IMG_W-1; `eol` is set on that pixel and y increments.
  - y wraps to 0 after the last line.
- Accumulators are seeded from the sof pixel: min = max = sum = pixel.
  - Subsequent pixels update them as min = min(min, p), max = max(max, p), sum += p.
  - The sum is unsigned and cannot overflow at the specified width.
- `stat_mean` = sum >> (clog2(IMG_W) + clog2(IMG_H)), truncating.
- At eof, the final values, including the eof pixel, are loaded into the stats registers and `stats_valid` is set.
- `stats_valid` stays high until a cycle with `stats_ready` = 1 clears it.
- If a new eof load arrives while `stats_valid` = 1 and `stats_ready` = 0:
  - the new record overwrites the old one;
  - `stats_valid` stays 1;
  - `stat_overrun` is set and stays set until `rst`.
- If the eof load and `stats_ready` occur in the same cycle, the new record is loaded, `stats_valid` stays 1, and there is no overrun.
- `frame_restart` clears x, y and the accumulators and forces IDLE.
  - Stats registers and `stats_valid` are unaffected.
  - If `valid_in` is high in the same cycle, that pixel is treated as the sof of the new frame.
- `rst` mid-frame discards the partial frame, with no stats load.

## Timing
- Pixel path latency is exactly 1 cycle: `valid_out` at cycle N+1 for `valid_in` at cycle N.
  - `valid_out` is 0 in cycles with no input.
- `stats_valid` rises in the same cycle as `eof_out`, one cycle after the last pixel is accepted.
- The block supports back-to-back frames at one pixel per cycle with no gap.
- Reset values: every output is 0, FSM is IDLE, counters are 0, `stat_overrun` is 0.

## Configuration
- `FRAME_STATS_EN` defined:
  - min/max/sum/mean accumulators, stats handshake and overrun logic are present.
- `FRAME_STATS_EN` undefined:
  - no accumulators are built;
  - `stats_valid`, `stat_*` and `stat_overrun` are tied to 0;
  - `stats_ready` is ignored.
  - Pixel path, tags and FSM are identical in both builds.

## Structure
- A shared package `img_pkg` holds:
  - `PIX_W` = 8;
  - the FSM state typedef (`ST_IDLE`, `ST_ACTIVE`);
  - a `frame_stats_t` struct of min/max/sum/mean.
- One sub-module, `frame_accum`, holds the min/max/sum accumulators and the mean shift.
  - It is instantiated only under `FRAME_STATS_EN`.

## Test plan
- 8×8 ramp of 0..63, continuous valid:
  - `sof` on pixel 0, `eol` on every 8th pixel, `eof` on pixel 63;
  - stats min 0, max 63, sum 2016, mean 31; `stats_valid` rises with `eof_out`.
- Same ramp with a random 50% valid duty:
  - identical tags and stats;
  - `valid_out` mirrors `valid_in` delayed by 1 cycle.
- Frame of all 255 then frame of all 0, with `stats_ready` held at 0:
  - the second record (sum 0) overwrites the first (sum 16320, mean 255);
  - `stat_overrun` = 1.
- `frame_restart` together with `valid_in` after 20 pixels, followed by 64 pixels of value 10:
  - `sof` on the restart pixel;
  - stats min 10, max 10, sum 640, mean 10.
- `rst` asserted at pixel 30:
  - all outputs go to 0 immediately;
  - the next pixel after release is `sof` at (0,0).
- With `FRAME_STATS_EN` undefined, run the ramp:
  - tags unchanged; `stats_valid` is never 1.
